// File: rtl/stream_pkg.sv
// Shared types and constants for the word-stream source and its FIFO.
package stream_pkg;

  // Default stream word width.
  localparam int DEFAULT_DW = 16;

  // Command sequencing states of the stream source.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Source selection latched with each accepted start.
  localparam logic MODE_FIFO    = 1'b0;
  localparam logic MODE_PATTERN = 1'b1;

  // Next word of the incrementing test pattern; wraps naturally at 2^16.
  function automatic logic [DEFAULT_DW-1:0] next_pattern(input logic [DEFAULT_DW-1:0] cur);
    return cur + DEFAULT_DW'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO. Pointers carry one extra wrap bit so
// that full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstb,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_level;
  logic          w_push;
  logic          w_pop;

  // Occupancy and flags come straight from the registered pointers, so they
  // only reflect writes and pops of earlier edges.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_level = w_level;
  assign o_full  = (w_level == (AW+1)'(DEPTH));
  assign o_empty = (w_level == '0);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A write while full is dropped even if a pop happens on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer advance with synchronous active-low reset to the empty state.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/word_stream_source.sv
// Word source for the valid/ready stream: sends exactly `count` words per
// start, either from the host-loaded FIFO or as an incrementing pattern,
// and reports completion and FIFO underrun.
module word_stream_source
  import stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                     i_clk,
  input  logic                     i_rstb,
  input  logic                     i_wr_en,
  input  logic [DW-1:0]            i_wr_data,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [15:0]              i_count,
  input  logic [DW-1:0]            i_seed,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_underrun,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DW-1:0]            o_dout
);

  state_t        r_state;
  logic [15:0]   r_remaining;
  logic [DW-1:0] r_pat;
  logic          r_mode;
  logic          r_busy;
  logic          r_done;
  logic          r_underrun;

  logic [DW-1:0] w_head;
  logic          w_empty;
  logic          w_valid;
  logic          w_xfer;
  logic          w_pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_push  (i_wr_en),
    .i_data  (i_wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Stream handshake is derived only from registered state and the FIFO
  // pointers, never from ready, so downstream cannot form a loop through us.
  assign w_valid = (r_state == SEND) && ((r_mode == MODE_PATTERN) || !w_empty);
  assign w_xfer  = w_valid & i_ready;
  assign w_pop   = w_xfer & (r_mode == MODE_FIFO);

  assign o_valid    = w_valid;
  assign o_dout     = w_valid ? ((r_mode == MODE_PATTERN) ? r_pat : w_head) : '0;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_underrun = r_underrun;

  // Command FSM with the word counter, pattern register and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_pat       <= '0;
      r_mode      <= MODE_FIFO;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            if (i_count != 16'd0) begin
              r_remaining <= i_count;
              r_mode      <= i_mode;
              r_pat       <= i_seed;
              r_underrun  <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= SEND;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        SEND: begin
          if ((r_mode == MODE_FIFO) && w_empty) begin
            r_underrun <= 1'b1;
          end
          if (w_xfer) begin
            r_remaining <= r_remaining - 16'd1;
            if (r_mode == MODE_PATTERN) begin
              r_pat <= next_pattern(r_pat);
            end
            if (r_remaining == 16'd1) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_stream_source.sv
// Scoreboard bench for word_stream_source: stimulus drives after each rising
// edge, a negedge monitor keeps a queue-based reference and compares.
module tb_word_stream_source;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstb;
  logic          wrEn;
  logic [DW-1:0] wrData;
  logic          full;
  logic [LW-1:0] level;
  logic          start;
  logic          mode;
  logic [15:0]   count;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          underrun;
  logic          valid;
  logic          ready;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  word_stream_source #(.DEPTH(DEPTH), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rstb     (rstb),
    .i_wr_en    (wrEn),
    .i_wr_data  (wrData),
    .o_full     (full),
    .o_level    (level),
    .i_start    (start),
    .i_mode     (mode),
    .i_count    (count),
    .i_seed     (seed),
    .o_busy     (busy),
    .o_done     (done),
    .o_underrun (underrun),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_dout     (dout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference state: words owed, the source of the current command, the
  // expected pattern words, and the FIFO contents as the host sees them.
  int            owed = 0;
  bit            modeCur = 1'b0;
  bit            doneNow = 1'b0;
  bit            underrunExp = 1'b0;
  bit            started = 1'b0;
  bit            justReset = 1'b0;
  bit            holdPending = 1'b0;
  logic [DW-1:0] prevDout = '0;
  logic [DW-1:0] patQ[$];
  logic [DW-1:0] fifoQ[$];

  // Monitor: compare this cycle's outputs, then advance the reference by
  // the inputs that will be sampled on the coming rising edge.
  always @(negedge clk) begin : monitor
    bit            expValid;
    bit            newDone;
    bit            accept;
    int            sizeBefore;
    int            owedBefore;
    logic [DW-1:0] front;

    sizeBefore = fifoQ.size();
    owedBefore = owed;
    expValid   = (owed > 0) && (modeCur || (fifoQ.size() > 0));

    if (started) begin
      checkOutput("valid", valid, expValid);
      checkOutput("busy", busy, owed > 0);
      checkOutput("done", done, doneNow);
      checkOutput("underrun", underrun, underrunExp);
      checkOutput("level", level, fifoQ.size());
      checkOutput("full", full, fifoQ.size() == DEPTH);
      if (justReset) checkOutput("dout_reset", dout, 0);
      if (holdPending && valid) checkOutput("dout_hold", dout, prevDout);
      if (expValid) begin
        if (modeCur ? (patQ.size() == 0) : (fifoQ.size() == 0)) begin
          checkOutput("scoreboard_empty", 1, 0);
        end else begin
          front = modeCur ? patQ[0] : fifoQ[0];
          checkOutput("dout", dout, front);
          if (ready) begin
            if (modeCur) void'(patQ.pop_front());
            else         void'(fifoQ.pop_front());
          end
        end
      end
    end

    if (!rstb) begin
      owed        = 0;
      doneNow     = 1'b0;
      underrunExp = 1'b0;
      holdPending = 1'b0;
      patQ.delete();
      fifoQ.delete();
      started     = 1'b1;
      justReset   = 1'b1;
    end else if (started) begin
      justReset = 1'b0;
      newDone   = 1'b0;
      accept    = wrEn && (sizeBefore < DEPTH);
      if ((owedBefore > 0) && !modeCur && (sizeBefore == 0)) underrunExp = 1'b1;
      if (expValid && ready) begin
        owed--;
        if (owed == 0) newDone = 1'b1;
      end
      if (start && (owedBefore == 0) && !doneNow) begin
        if (count == 16'd0) begin
          newDone = 1'b1;
        end else begin
          owed        = count;
          modeCur     = mode;
          underrunExp = 1'b0;
          patQ.delete();
          if (mode) for (int i = 0; i < count; i++) patQ.push_back(seed + DW'(i));
        end
      end
      if (accept) fifoQ.push_back(wrData);
      holdPending = expValid && !ready;
      prevDout    = dout;
      doneNow     = newDone;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of host and command inputs.
  task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit s,
                               input bit m, input logic [15:0] c, input logic [DW-1:0] sd);
    wrEn   = w;
    wrData = d;
    start  = s;
    mode   = m;
    count  = c;
    seed   = sd;
    step();
    wrEn   = 1'b0;
    start  = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input bit toggle);
    int n;
    n = 0;
    while ((busy || done) && (n < budget)) begin
      if (toggle) ready = ~ready;
      step();
      n++;
    end
    checks++;
    if (busy || done) begin
      errors++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  initial begin
    rstb = 1'b0; wrEn = 1'b0; wrData = '0; start = 1'b0;
    mode = 1'b0; count = '0; seed = '0; ready = 1'b0;
    repeat (3) step();
    rstb = 1'b1;
    step();

    $display("[TB] pattern wrap from FFFE");
    ready = 1'b1;
    applyStimulus(0, '0, 1, 1, 16'd4, 16'hFFFE);
    checkOutput("pattern_first", dout, 16'hFFFE);
    waitIdle(50, 0);
    step();

    $display("[TB] FIFO mode with ready toggling");
    ready = 1'b0;
    applyStimulus(1, 16'hA000, 0, 0, 0, 0);
    applyStimulus(1, 16'hB111, 0, 0, 0, 0);
    applyStimulus(1, 16'hC222, 0, 0, 0, 0);
    ready = 1'b1;
    applyStimulus(0, '0, 1, 0, 16'd3, 0);
    waitIdle(50, 1);
    checkOutput("level_after_abc", level, 0);
    step();

    $display("[TB] underrun then refill");
    ready = 1'b1;
    applyStimulus(1, 16'h1111, 0, 0, 0, 0);
    applyStimulus(1, 16'h2222, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 16'd5, 0);
    repeat (6) step();
    checkOutput("underrun_set", underrun, 1);
    applyStimulus(1, 16'h3333, 0, 0, 0, 0);
    applyStimulus(1, 16'h4444, 0, 0, 0, 0);
    applyStimulus(1, 16'h5555, 0, 0, 0, 0);
    waitIdle(50, 0);
    checkOutput("underrun_sticky", underrun, 1);
    step();

    $display("[TB] overfill by one word");
    ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1, DW'(16'h7000 + i), 0, 0, 0, 0);
    checkOutput("full_after_overfill", full, 1);
    checkOutput("level_after_overfill", level, DEPTH);
    ready = 1'b1;
    applyStimulus(0, '0, 1, 0, 16'(DEPTH), 0);
    checkOutput("underrun_cleared", underrun, 0);
    waitIdle(100, 0);
    step();

    $display("[TB] zero count and ignored start");
    applyStimulus(0, '0, 1, 1, 16'd0, 16'h1234);
    checkOutput("done_count0", done, 1);
    checkOutput("valid_count0", valid, 0);
    step();
    ready = 1'b0;
    applyStimulus(0, '0, 1, 1, 16'd6, 16'h0100);
    step();
    applyStimulus(0, '0, 1, 0, 16'd3, 16'h9999);
    checkOutput("ignored_start_dout", dout, 16'h0100);
    ready = 1'b1;
    waitIdle(50, 0);
    applyStimulus(0, '0, 1, 1, 16'd2, 16'h4242);
    step();

    $display("[TB] reset during send");
    applyStimulus(1, 16'hDEAD, 0, 0, 0, 0);
    applyStimulus(1, 16'hBEEF, 0, 0, 0, 0);
    ready = 1'b1;
    applyStimulus(0, '0, 1, 1, 16'd10, 16'h0050);
    repeat (2) step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", level, 0);
    repeat (3) step();

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready = ($urandom_range(0, 9) < 7);
      applyStimulus(($urandom_range(0, 9) < 3), DW'($urandom),
                    ($urandom_range(0, 19) == 0), 1'($urandom),
                    16'($urandom_range(0, 8)), DW'($urandom));
    end
    ready = 1'b1;
    for (int n = 0; (n < 1000) && (busy || done); n++) begin
      applyStimulus(1, DW'($urandom), 0, 0, 0, 0);
    end
    waitIdle(10, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_stream_source.md
# word_stream_source

Synthesizable 16-bit word source that drives the tester's valid/ready word-stream interface, the same interface consumed by the results-logging sink. It accepts host-loaded words into a small FIFO, or generates an incrementing test pattern. It sends exactly `count` words per start command under downstream backpressure and reports completion and FIFO underrun.

## Interface
Parameters:
- `DEPTH`, 16, FIFO depth in words; power of two, ≥ 2.
- `DW`, 16, word width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rstb`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  host FIFO write strobe.
- `wr_data`  in  DW  host write word.
- `full`  out  1  FIFO holds DEPTH words.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `start`  in  1  one-cycle command strobe.
- `mode`  in  1  0 = send FIFO words, 1 = send incrementing pattern; sampled on accepted start.
- `count`  in  16  words to send; sampled on accepted start.
- `seed`  in  DW  first pattern word; sampled on accepted start.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `underrun`  out  1  sticky: FIFO was empty while words were still owed in FIFO mode.
- `valid`  out  1  stream word available.
- `ready`  in  1  downstream accepts.
- `dout`  out  DW  stream word.

## Operation
- FSM states:
  - IDLE: waiting for a command.
  - SEND: transferring words.
  - DONE: one cycle, `done`=1, `busy`=0, then returns to IDLE.
- IDLE, `start`=1, `count`≠0: latch `count`, `mode` and `seed` into `remaining`, `mode_q` and `pat`; clear `underrun`; go to SEND.
- IDLE, `start`=1, `count`=0: go to DONE directly. No words are sent and `underrun` is unchanged.
- `start` in SEND or DONE is ignored.
- SEND drives `valid` as follows:
  - `mode_q`=1: `valid`=1.
  - `mode_q`=0: `valid` = FIFO not empty.
- `dout` drives `pat` in pattern mode and the FIFO head in FIFO mode.
- A transfer occurs when `valid & ready`. Each transfer:
  - decrements `remaining`;
  - pops the FIFO (mode 0) or increments `pat` modulo 2^DW (mode 1; 16'hFFFF wraps to 16'h0000).
- The transfer that brings `remaining` to 0 moves the FSM to DONE.
- `underrun` is set in any SEND cycle with `mode_q`=0 and the FIFO empty. The transfer then stalls until the host writes more words; it does not abort.
- FIFO write is accepted when `wr_en & !full`. A write while full is dropped silently, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: `level` is unchanged and ordering is preserved.
- Host writes are allowed in every state. Pattern mode leaves FIFO contents untouched.
- `valid`, `dout`, `busy` and `done` must not depend combinationally on `ready`.

## Timing
- Reset (`rstb`=0 at a posedge) forces:
  - state IDLE and an empty FIFO;
  - `valid`=0, `busy`=0, `done`=0, `underrun`=0, `full`=0, `level`=0;
  - `dout`=0, `remaining`=0, `pat`=0.
- Reset mid-SEND abandons the command with no `done` pulse.
- Start latency: `start` at edge N gives `busy`=1 from cycle N+1. In pattern mode, `valid`=1 with `dout`=`seed` also from cycle N+1.
- FIFO write latency: a word written at edge N is visible at the head and can raise `valid` at N+1. There is no same-cycle bypass.
- Throughput is one word per cycle while `ready`=1 and data is available.
- While `valid`=1 and `ready`=0, `dout` holds stable.
- `done` rises the cycle after the last transfer edge and lasts exactly one cycle. `busy` falls in that same cycle. A new `start` is accepted from the following cycle.
- `level` and `full` are registered and reflect all writes and pops of the previous edge.

## Structure
- Package `stream_pkg`:
  - `DW` default;
  - `state_t` enum {IDLE, SEND, DONE};
  - `MODE_FIFO`=0, `MODE_PATTERN`=1.
- Sub-module `sync_fifo` (parameters DEPTH, DW): circular buffer with read/write pointers one bit wider than the address, a combinational head output, `full`, `empty` and `level`.
- The top level contains the FSM, the `remaining` counter, the `pat` register and the output mux.

## Test plan
- Pattern, seed 16'hFFFE, count 4, `ready`=1: `dout` = FFFE, FFFF, 0000, 0001 on consecutive cycles, then a `done` pulse and `valid`=0.
- FIFO mode with 3 preloaded words (A, B, C), count 3, `ready` toggling 1/0: each word is held stable while `ready`=0, A, B and C are sent exactly once, and `level` ends at 0.
- FIFO mode, count 5, 2 words preloaded: `underrun`=1 after the 2nd transfer. Later write 3 words: the transfer completes with `done`, and `underrun` stays 1 until the next accepted start.
- Write DEPTH+1 words back-to-back: `full`=1 and `level`=DEPTH. The extra word is dropped, and a later FIFO-mode send of DEPTH words returns only the first DEPTH written.
- `start` with count 0: `done` pulses at N+1, `valid` never rises, and a `start` issued during SEND is ignored.
- Assert `rstb`=0 mid-SEND with `valid`=1: next cycle all outputs are at reset values, there is no `done`, and FIFO `level`=0.
